reg_file: RTL and testbench

Architectural register file with rename tags for the out-of-order core. Holds x0–x31 values plus, per register, the reorder-buffer id of the youngest in-flight writer. Sits between the issuer (source lookup and destination rename) and the reorder buffer: it is the receiving end of the ROB commit port (`dest`/`rd`/`value`) and of the ROB flush line.

---
 rtl/reg_file.sv | 116 +++++++++++
 tb/tb_reg_file.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// Architectural register file with rename tags. Each of x1..x31 stores a value
// and the ROB id of its youngest in-flight writer (tag 0 = value is final).
// x0 is hardwired: it reads as value 0 with tag 0, and writes or renames to it
// are ignored.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset (clears all state)
//   rdy                  global enable; low holds all state
//   valid_from_issuer    an instruction is issued this cycle
//   rs1/rs2_from_issuer  source register ids for lookup
//   rd_from_issuer       destination register to rename (0 = none)
//   dest_from_issuer     ROB id allocated to the issued instruction
//   qj/qk_to_issuer      producer tag of rs1/rs2 (0 = value available)
//   vj/vk_to_issuer      value of rs1/rs2 (meaningful only when q = 0)
//   dest_from_rob        committing ROB id (0 = no commit)
//   rd_from_rob          committing destination register
//   value_from_rob       committed value
//   reset_from_rob_bus   misprediction flush: clears every tag, keeps values
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int XLEN         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    valid_from_issuer,
    input  logic [4:0]              rs1_from_issuer,
    input  logic [4:0]              rs2_from_issuer,
    input  logic [4:0]              rd_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
    output logic [XLEN-1:0]         vj_to_issuer,
    output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
    output logic [XLEN-1:0]         vk_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
    input  logic [4:0]              rd_from_rob,
    input  logic [XLEN-1:0]         value_from_rob,
    input  logic                    reset_from_rob_bus
);

    logic [XLEN-1:0]         value_q [1:31];
    logic [XLEN-1:0]         value_d [1:31];
    logic [ROB_ID_WIDTH-1:0] tag_q   [1:31];
    logic [ROB_ID_WIDTH-1:0] tag_d   [1:31];

    logic commit_vld;
    logic rename_vld;

    assign commit_vld = (dest_from_rob != '0) && (rd_from_rob != 5'd0);
    assign rename_vld = valid_from_issuer && (rd_from_issuer != 5'd0);

    // Lookup sees pre-edge state, so an instruction reading its own
    // destination gets the previous producer. A commit in flight for the
    // current producer is forwarded so the issuer never waits a cycle extra.
    function automatic logic [ROB_ID_WIDTH+XLEN-1:0] lookup(input logic [4:0] r);
        logic [ROB_ID_WIDTH-1:0] q;
        logic [XLEN-1:0]         v;
        q = '0;
        v = '0;
        if (r != 5'd0) begin
            if (tag_q[r] == '0) begin
                v = value_q[r];
            end else if (tag_q[r] == dest_from_rob) begin
                v = value_from_rob;
            end else begin
                q = tag_q[r];
            end
        end
        return {q, v};
    endfunction

    assign {qj_to_issuer, vj_to_issuer} = lookup(rs1_from_issuer);
    assign {qk_to_issuer, vk_to_issuer} = lookup(rs2_from_issuer);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;

        if (commit_vld) begin
            value_d[rd_from_rob] = value_from_rob;
            // Only the writer that owns the tag may release it; a younger
            // rename keeps the register pending.
            if (tag_q[rd_from_rob] == dest_from_rob) begin
                tag_d[rd_from_rob] = '0;
            end
        end

        // Flush discards every outstanding producer, including any rename
        // issued in the same cycle. Otherwise rename overrides the commit's
        // tag clear on the same register.
        if (reset_from_rob_bus) begin
            for (int i = 1; i < 32; i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_vld) begin
            tag_d[rd_from_issuer] = dest_from_issuer;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    localparam int RW = 4;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          valid_from_issuer;
    logic [4:0]    rs1_from_issuer;
    logic [4:0]    rs2_from_issuer;
    logic [4:0]    rd_from_issuer;
    logic [RW-1:0] dest_from_issuer;
    logic [RW-1:0] qj_to_issuer;
    logic [XL-1:0] vj_to_issuer;
    logic [RW-1:0] qk_to_issuer;
    logic [XL-1:0] vk_to_issuer;
    logic [RW-1:0] dest_from_rob;
    logic [4:0]    rd_from_rob;
    logic [XL-1:0] value_from_rob;
    logic          reset_from_rob_bus;

    int errors = 0;
    int checks = 0;

    reg_file #(.ROB_ID_WIDTH(RW), .XLEN(XL)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .valid_from_issuer  (valid_from_issuer),
        .rs1_from_issuer    (rs1_from_issuer),
        .rs2_from_issuer    (rs2_from_issuer),
        .rd_from_issuer     (rd_from_issuer),
        .dest_from_issuer   (dest_from_issuer),
        .qj_to_issuer       (qj_to_issuer),
        .vj_to_issuer       (vj_to_issuer),
        .qk_to_issuer       (qk_to_issuer),
        .vk_to_issuer       (vk_to_issuer),
        .dest_from_rob      (dest_from_rob),
        .rd_from_rob        (rd_from_rob),
        .value_from_rob     (value_from_rob),
        .reset_from_rob_bus (reset_from_rob_bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; valid_from_issuer = 1'b0;
        rs1_from_issuer = 5'd0; rs2_from_issuer = 5'd0;
        rd_from_issuer = 5'd0; dest_from_issuer = '0;
        dest_from_rob = '0; rd_from_rob = 5'd0; value_from_rob = '0;
        reset_from_rob_bus = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] dest);
        valid_from_issuer = 1'b1; rd_from_issuer = rd; dest_from_issuer = dest;
        step();
        valid_from_issuer = 1'b0; rd_from_issuer = 5'd0; dest_from_issuer = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rs1_from_issuer = 5'd5; rs2_from_issuer = 5'd0;
        #1;
        checks++; if (qj_to_issuer !== 4'd0) begin errors++; $display("FAIL reset_qj got=%0d exp=0", qj_to_issuer); end
        checks++; if (vj_to_issuer !== 32'd0) begin errors++; $display("FAIL reset_vj got=%h exp=0", vj_to_issuer); end
        checks++; if (qk_to_issuer !== 4'd0) begin errors++; $display("FAIL reset_qk got=%0d exp=0", qk_to_issuer); end
        checks++; if (vk_to_issuer !== 32'd0) begin errors++; $display("FAIL reset_vk got=%h exp=0", vk_to_issuer); end
        for (int r = 1; r < 32; r++) begin
            rs1_from_issuer = 5'(r);
            #1;
            checks++;
            if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0) begin
                errors++; $display("FAIL reset_all r=%0d got q=%0d v=%h exp q=0 v=0", r, qj_to_issuer, vj_to_issuer);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        issue(5'd3, 4'd2);
        rs1_from_issuer = 5'd3;
        #1;
        checks++; if (qj_to_issuer !== 4'd2 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL pending_x3 got q=%0d v=%h exp q=2 v=0", qj_to_issuer, vj_to_issuer); end
        dest_from_rob = 4'd2; rd_from_rob = 5'd3; value_from_rob = 32'hDEAD;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'hDEAD) begin errors++; $display("FAIL bypass_x3 got q=%0d v=%h exp q=0 v=dead", qj_to_issuer, vj_to_issuer); end
        step();
        dest_from_rob = '0; rd_from_rob = 5'd0; value_from_rob = '0;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'hDEAD) begin errors++; $display("FAIL committed_x3 got q=%0d v=%h exp q=0 v=dead", qj_to_issuer, vj_to_issuer); end
    endtask

    task automatic test_younger_writer();
        idle();
        issue(5'd4, 4'd1);
        issue(5'd4, 4'd5);
        dest_from_rob = 4'd1; rd_from_rob = 5'd4; value_from_rob = 32'd7;
        rs1_from_issuer = 5'd4;
        #1;
        checks++; if (qj_to_issuer !== 4'd5 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL older_commit_nobypass got q=%0d v=%h exp q=5 v=0", qj_to_issuer, vj_to_issuer); end
        step();
        dest_from_rob = '0; rd_from_rob = 5'd0; value_from_rob = '0;
        #1;
        checks++; if (qj_to_issuer !== 4'd5 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL tag_kept_x4 got q=%0d v=%h exp q=5 v=0", qj_to_issuer, vj_to_issuer); end
        // Flush exposes the stored value written by the older commit.
        reset_from_rob_bus = 1'b1;
        step();
        reset_from_rob_bus = 1'b0;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd7) begin errors++; $display("FAIL value_x4 got q=%0d v=%h exp q=0 v=7", qj_to_issuer, vj_to_issuer); end
    endtask

    task automatic test_same_edge();
        idle();
        issue(5'd6, 4'd2);
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd6; dest_from_issuer = 4'd3;
        dest_from_rob = 4'd2; rd_from_rob = 5'd6; value_from_rob = 32'd9;
        rs2_from_issuer = 5'd6;
        #1;
        checks++; if (qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd9) begin errors++; $display("FAIL same_edge_lookup got q=%0d v=%h exp q=0 v=9", qk_to_issuer, vk_to_issuer); end
        step();
        valid_from_issuer = 1'b0; rd_from_issuer = 5'd0; dest_from_issuer = '0;
        dest_from_rob = '0; rd_from_rob = 5'd0; value_from_rob = '0;
        #1;
        checks++; if (qk_to_issuer !== 4'd3 || vk_to_issuer !== 32'd0) begin errors++; $display("FAIL rename_wins_tag got q=%0d v=%h exp q=3 v=0", qk_to_issuer, vk_to_issuer); end
        reset_from_rob_bus = 1'b1;
        step();
        reset_from_rob_bus = 1'b0;
        #1;
        checks++; if (qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd9) begin errors++; $display("FAIL commit_value_x6 got q=%0d v=%h exp q=0 v=9", qk_to_issuer, vk_to_issuer); end
    endtask

    task automatic test_flush();
        idle();
        issue(5'd1, 4'd4);
        issue(5'd2, 4'd6);
        reset_from_rob_bus = 1'b1;
        dest_from_rob = 4'd4; rd_from_rob = 5'd1; value_from_rob = 32'h100;
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd2; dest_from_issuer = 4'd7;
        step();
        idle();
        rs1_from_issuer = 5'd1; rs2_from_issuer = 5'd2;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'h100) begin errors++; $display("FAIL flush_x1 got q=%0d v=%h exp q=0 v=100", qj_to_issuer, vj_to_issuer); end
        checks++; if (qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0) begin errors++; $display("FAIL flush_x2 got q=%0d v=%h exp q=0 v=0", qk_to_issuer, vk_to_issuer); end
        rs1_from_issuer = 5'd3; rs2_from_issuer = 5'd4;
        #1;
        checks++; if (vj_to_issuer !== 32'hDEAD || vk_to_issuer !== 32'd7) begin errors++; $display("FAIL flush_keeps_values got vj=%h vk=%h exp vj=dead vk=7", vj_to_issuer, vk_to_issuer); end
    endtask

    task automatic test_rdy_hold();
        idle();
        rdy = 1'b0;
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd8; dest_from_issuer = 4'd4;
        dest_from_rob = 4'd1; rd_from_rob = 5'd9; value_from_rob = 32'd1;
        step();
        idle();
        rs1_from_issuer = 5'd8; rs2_from_issuer = 5'd9;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL hold_x8 got q=%0d v=%h exp q=0 v=0", qj_to_issuer, vj_to_issuer); end
        checks++; if (qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0) begin errors++; $display("FAIL hold_x9 got q=%0d v=%h exp q=0 v=0", qk_to_issuer, vk_to_issuer); end
    endtask

    task automatic test_x0();
        idle();
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd0; dest_from_issuer = 4'd5;
        dest_from_rob = 4'd3; rd_from_rob = 5'd0; value_from_rob = 32'h55;
        rs1_from_issuer = 5'd0;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL x0_comb got q=%0d v=%h exp q=0 v=0", qj_to_issuer, vj_to_issuer); end
        step();
        idle();
        rs1_from_issuer = 5'd0; rs2_from_issuer = 5'd0;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0 || qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0) begin
            errors++; $display("FAIL x0_after got qj=%0d vj=%h qk=%0d vk=%h exp all 0", qj_to_issuer, vj_to_issuer, qk_to_issuer, vk_to_issuer);
        end
    endtask

    task automatic test_reset_override();
        idle();
        issue(5'd10, 4'd3);
        rst = 1'b1; rdy = 1'b0;
        dest_from_rob = 4'd9; rd_from_rob = 5'd11; value_from_rob = 32'h77;
        valid_from_issuer = 1'b1; rd_from_issuer = 5'd12; dest_from_issuer = 4'd2;
        step();
        idle();
        rs1_from_issuer = 5'd10; rs2_from_issuer = 5'd1;
        #1;
        checks++; if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0) begin errors++; $display("FAIL rst_tag_x10 got q=%0d v=%h exp q=0 v=0", qj_to_issuer, vj_to_issuer); end
        checks++; if (qk_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0) begin errors++; $display("FAIL rst_value_x1 got q=%0d v=%h exp q=0 v=0", qk_to_issuer, vk_to_issuer); end
        rs1_from_issuer = 5'd11; rs2_from_issuer = 5'd12;
        #1;
        checks++; if (vj_to_issuer !== 32'd0 || qk_to_issuer !== 4'd0) begin errors++; $display("FAIL rst_overrides got vj=%h qk=%0d exp vj=0 qk=0", vj_to_issuer, qk_to_issuer); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_younger_writer();
        test_same_edge();
        test_flush();
        test_rdy_hold();
        test_x0();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
